instr_inv_queue: RTL and testbench

INSTR_INV_QUEUE -- requirements
Module: instr_inv_queue

---
 rtl/instr_inv_queue.sv | 136 +++++++++++++
 tb/tb_instr_inv_queue.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/instr_inv_queue.sv
// instr_inv_queue
//   Collects committed data stores that hit the cacheable instruction
//   region and turns them into line-aligned invalidation requests for the
//   instruction cache, one outstanding request at a time.
//
// Parameters
//   DEPTH   queue entries (power of 2, 2..8)
//   LINE_W  instruction-cache line width in 32-bit words (power of 2)
//   ADDR_L  lowest cacheable instruction address (inclusive)
//   ADDR_H  highest cacheable instruction address (inclusive)
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   store_valid/addr    committed store from the data side, never stalled
//   inv_valid/addr      invalidation request to the I-cache, held until ready
//   inv_ready           I-cache accepts the current request
//   inv_done            one-cycle pulse when the accepted request completes
//   drained             queue empty and nothing outstanding
//   status_clear        clears the sticky overflow flag
//   status              {busy, overflow, empty, full, count[3:0]}
//
// Optional feature
//   INSTR_INV_QUEUE_COALESCE_EN: when defined, a store to the same line as
//   the youngest queued entry is merged into that entry instead of pushed.
module instr_inv_queue #(
  parameter int          DEPTH  = 4,
  parameter int          LINE_W = 4,
  parameter logic [31:0] ADDR_L = 32'h80000000,
  parameter logic [31:0] ADDR_H = 32'h8FFFFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        store_valid,
  input  logic [31:0] store_addr,
  output logic        inv_valid,
  output logic [31:0] inv_addr,
  input  logic        inv_ready,
  input  logic        inv_done,
  output logic        drained,
  input  logic        status_clear,
  output logic [7:0]  status
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OFF   = $clog2(LINE_W) + 2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

  state_t             state, state_next;
  logic [31:0]        mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count, count_next;
  logic               overflow;
  logic               in_range, coalesce, is_full, pop, push, drop;
  logic [31:0]        line_addr;

  assign in_range  = store_valid && (store_addr >= ADDR_L) && (store_addr <= ADDR_H);
  assign line_addr = {store_addr[31:OFF], {OFF{1'b0}}};
  assign is_full   = (count == CNT_W'(DEPTH));

  // The head leaves the queue on the handshake cycle; ISSUE is only ever
  // entered with a non-empty queue, the count check just keeps it safe.
  assign pop = (state == ISSUE) && inv_ready && (count != '0);

`ifdef INSTR_INV_QUEUE_COALESCE_EN
  logic [PTR_W-1:0] last_ptr;
  logic [CNT_W-1:0] count_after_pop;

  // Compare against the youngest entry only if it survives this cycle's pop.
  assign last_ptr        = wr_ptr - PTR_W'(1);
  assign count_after_pop = count - CNT_W'(pop);
  assign coalesce        = in_range && (count_after_pop != '0) && (mem[last_ptr] == line_addr);
`else
  assign coalesce = 1'b0;
`endif

  // A full queue still takes a push when the head pops in the same cycle;
  // a merged store never counts as an overflow.
  assign drop       = in_range && !coalesce && is_full && !pop;
  assign push       = in_range && !coalesce && !drop;
  assign count_next = count + CNT_W'(push) - CNT_W'(pop);

  // Entry storage has no reset: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= line_addr;
  end

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
      if (drop)              overflow <= 1'b1;
      else if (status_clear) overflow <= 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and request outputs. Leaving IDLE looks at count_next so a
  // store reaches inv_valid one cycle after it is presented.
  always_comb begin
    state_next = state;
    inv_valid  = 1'b0;
    inv_addr   = '0;
    case (state)
      IDLE: begin
        if (count_next != '0) state_next = ISSUE;
      end
      ISSUE: begin
        inv_valid = 1'b1;
        inv_addr  = mem[rd_ptr];
        if (inv_ready) state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (inv_done) state_next = (count_next != '0) ? ISSUE : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign drained = (count == '0) && (state == IDLE);
  assign status  = {(state != IDLE), overflow, (count == '0), is_full, 4'(count)};

endmodule

// File: tb/tb_instr_inv_queue.sv
// tb_instr_inv_queue
//   Directed bench for instr_inv_queue with default parameters. Inputs are
//   driven 1 time unit after the rising edge and outputs are sampled there
//   too, away from the edge. Build with INSTR_INV_QUEUE_COALESCE_EN defined
//   to exercise the coalescing variant.
module tb_instr_inv_queue;

  logic        clk;
  logic        rst_n;
  logic        store_valid;
  logic [31:0] store_addr;
  logic        inv_valid;
  logic [31:0] inv_addr;
  logic        inv_ready;
  logic        inv_done;
  logic        drained;
  logic        status_clear;
  logic [7:0]  status;

  int checks = 0;
  int errors = 0;

`ifdef INSTR_INV_QUEUE_COALESCE_EN
  localparam logic [7:0] COAL_STATUS = 8'h81;
`else
  localparam logic [7:0] COAL_STATUS = 8'h82;
`endif

  instr_inv_queue dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .store_valid  (store_valid),
    .store_addr   (store_addr),
    .inv_valid    (inv_valid),
    .inv_addr     (inv_addr),
    .inv_ready    (inv_ready),
    .inv_done     (inv_done),
    .drained      (drained),
    .status_clear (status_clear),
    .status       (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // One comparison: counted, and reported with tag/observed/expected on failure.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a single-cycle store.
  task automatic pushStore(input logic [31:0] addr);
    store_valid = 1'b1;
    store_addr  = addr;
    applyStimulus();
    store_valid = 1'b0;
    store_addr  = '0;
  endtask

  initial begin
    rst_n        = 1'b0;
    store_valid  = 1'b0;
    store_addr   = '0;
    inv_ready    = 1'b0;
    inv_done     = 1'b0;
    status_clear = 1'b0;

    // Reset values.
    #3;
    checkOutput("rst_status",  32'(status),    32'h20);
    checkOutput("rst_drained", 32'(drained),   32'h1);
    checkOutput("rst_valid",   32'(inv_valid), 32'h0);
    checkOutput("rst_addr",    inv_addr,       32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus();

    // Out-of-range store is ignored.
    pushStore(32'h60000000);
    checkOutput("oor_status", 32'(status),    32'h20);
    checkOutput("oor_valid",  32'(inv_valid), 32'h0);
    applyStimulus();
    checkOutput("oor_status2", 32'(status), 32'h20);

    // Single store, accepted immediately, done two cycles later.
    inv_ready = 1'b1;
    pushStore(32'h80000104);
    checkOutput("one_valid",   32'(inv_valid), 32'h1);
    checkOutput("one_addr",    inv_addr,       32'h80000100);
    checkOutput("one_status",  32'(status),    32'h81);
    checkOutput("one_drained", 32'(drained),   32'h0);
    applyStimulus();
    checkOutput("wait_valid",  32'(inv_valid), 32'h0);
    checkOutput("wait_status", 32'(status),    32'hA0);
    applyStimulus();
    checkOutput("wait_status2", 32'(status), 32'hA0);
    inv_done = 1'b1;
    applyStimulus();
    inv_done = 1'b0;
    checkOutput("done_drained", 32'(drained), 32'h1);
    checkOutput("done_status",  32'(status),  32'h20);

    // Five distinct lines with the cache stalled: fills and overflows.
    inv_ready = 1'b0;
    for (int i = 0; i < 5; i++) pushStore(32'h80000000 + 32'(i * 16));
    checkOutput("ovf_status", 32'(status),    32'hD4);
    checkOutput("ovf_valid",  32'(inv_valid), 32'h1);
    checkOutput("ovf_addr",   inv_addr,       32'h80000000);
    status_clear = 1'b1;
    applyStimulus();
    status_clear = 1'b0;
    checkOutput("clr_status", 32'(status), 32'h94);

    // Full queue: push coinciding with the handshake is accepted.
    checkOutput("full_valid", 32'(inv_valid), 32'h1);
    inv_ready = 1'b1;
    pushStore(32'h80000050);
    inv_ready = 1'b0;
    checkOutput("fullpp_status", 32'(status),    32'h94);
    checkOutput("fullpp_valid",  32'(inv_valid), 32'h0);

    // Done with entries left goes straight back to ISSUE on the next head.
    inv_done = 1'b1;
    applyStimulus();
    inv_done = 1'b0;
    checkOutput("reissue_valid", 32'(inv_valid), 32'h1);
    checkOutput("reissue_addr",  inv_addr,       32'h80000010);

    // inv_done while in ISSUE is ignored.
    inv_done = 1'b1;
    applyStimulus();
    inv_done = 1'b0;
    checkOutput("ign_valid", 32'(inv_valid), 32'h1);
    checkOutput("ign_addr",  inv_addr,       32'h80000010);

    // Walk down to WAIT_DONE with two entries left, then reset mid-cycle.
    inv_ready = 1'b1;
    applyStimulus();
    inv_ready = 1'b0;
    inv_done  = 1'b1;
    applyStimulus();
    inv_done  = 1'b0;
    checkOutput("pre_addr", inv_addr, 32'h80000020);
    inv_ready = 1'b1;
    applyStimulus();
    inv_ready = 1'b0;
    checkOutput("pre_status", 32'(status), 32'h82);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mrst_status",  32'(status),    32'h20);
    checkOutput("mrst_drained", 32'(drained),   32'h1);
    checkOutput("mrst_valid",   32'(inv_valid), 32'h0);
    checkOutput("mrst_addr",    inv_addr,       32'h0);
    applyStimulus();
    rst_n = 1'b1;
    inv_done = 1'b1;
    applyStimulus();
    inv_done = 1'b0;
    checkOutput("late_status", 32'(status),    32'h20);
    checkOutput("late_valid",  32'(inv_valid), 32'h0);
    applyStimulus();
    checkOutput("late_drained", 32'(drained), 32'h1);

    // Two stores to the same line back to back.
    pushStore(32'h80000010);
    pushStore(32'h8000001C);
    checkOutput("coal_status", 32'(status), 32'(COAL_STATUS));
    checkOutput("coal_addr",   inv_addr,    32'h80000010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
